// File: rtl/decode_pipe_stage_if.sv
// Fetch/writeback/EX-hazard inputs and the registered ID/EX bundle of the decode stage.
// The stage connects through the slave modport and its environment through the master modport.
interface decode_pipe_stage_if #(
  parameter int DataWidth  = 32,
  parameter int RegAddress = 5
);
  logic                  if_valid;
  logic                  if_ready;
  logic [DataWidth-1:0]  if_instr;
  logic [DataWidth-1:0]  if_pc;
  logic                  wb_en;
  logic [RegAddress-1:0] wb_rd;
  logic [DataWidth-1:0]  wb_data;
  logic                  ex_load;
  logic [RegAddress-1:0] ex_rd;
  logic                  flush;
  logic                  stall;
  logic                  id_valid;
  logic                  id_ready;
  logic [DataWidth-1:0]  id_pc;
  logic [DataWidth-1:0]  id_imm;
  logic [DataWidth-1:0]  id_rs1_data;
  logic [DataWidth-1:0]  id_rs2_data;
  logic [RegAddress-1:0] id_rs1;
  logic [RegAddress-1:0] id_rs2;
  logic [RegAddress-1:0] id_rd;
  logic [6:0]            id_opcode;
  logic [2:0]            id_func3;
  logic                  id_func7b;

  modport slave (
    input  if_valid, if_instr, if_pc, wb_en, wb_rd, wb_data, ex_load, ex_rd, flush, id_ready,
    output if_ready, stall, id_valid, id_pc, id_imm, id_rs1_data, id_rs2_data,
           id_rs1, id_rs2, id_rd, id_opcode, id_func3, id_func7b
  );

  modport master (
    output if_valid, if_instr, if_pc, wb_en, wb_rd, wb_data, ex_load, ex_rd, flush, id_ready,
    input  if_ready, stall, id_valid, id_pc, id_imm, id_rs1_data, id_rs2_data,
           id_rs1, id_rs2, id_rd, id_opcode, id_func3, id_func7b
  );
endinterface

// File: rtl/decode_pipe_stage.sv
// RV32I decode stage: regfile read with optional WB bypass, immediate generation,
// load-use hazard detection and a registered ID/EX bundle with valid/ready and flush.
module decode_pipe_stage #(
  parameter int DataWidth  = 32,
  parameter int RegAddress = 5,
  parameter bit WbBypass   = 1'b1
) (
  input logic clk,
  input logic rst,
  decode_pipe_stage_if.slave bus
);
  localparam int Depth = 2 ** RegAddress;

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;

  logic [DataWidth-1:0]  rf_q [Depth];

  logic [DataWidth-1:0]  instr;
  logic [6:0]            opcode;
  logic [RegAddress-1:0] rs1;
  logic [RegAddress-1:0] rs2;
  logic [RegAddress-1:0] rd;
  logic [DataWidth-1:0]  rs1_data;
  logic [DataWidth-1:0]  rs2_data;
  logic [31:0]           imm32;
  logic [DataWidth-1:0]  imm_d;
  logic                  uses_rs1;
  logic                  uses_rs2;
  logic                  stall;
  logic                  if_ready;
  logic                  accept;
  logic                  wb_live;

  logic                  id_valid_q;
  logic [DataWidth-1:0]  id_pc_q;
  logic [DataWidth-1:0]  id_imm_q;
  logic [DataWidth-1:0]  id_rs1_data_q;
  logic [DataWidth-1:0]  id_rs2_data_q;
  logic [RegAddress-1:0] id_rs1_q;
  logic [RegAddress-1:0] id_rs2_q;
  logic [RegAddress-1:0] id_rd_q;
  logic [6:0]            id_opcode_q;
  logic [2:0]            id_func3_q;
  logic                  id_func7b_q;

  assign instr   = bus.if_instr;
  assign opcode  = instr[6:0];
  assign rs1     = instr[15 +: RegAddress];
  assign rs2     = instr[20 +: RegAddress];
  assign rd      = instr[7 +: RegAddress];
  assign wb_live = bus.wb_en && (bus.wb_rd != '0);

  always_comb begin
    rs1_data = rf_q[rs1];
    rs2_data = rf_q[rs2];
    if (WbBypass && wb_live && (bus.wb_rd == rs1)) rs1_data = bus.wb_data;
    if (WbBypass && wb_live && (bus.wb_rd == rs2)) rs2_data = bus.wb_data;
    if (rs1 == '0) rs1_data = '0;
    if (rs2 == '0) rs2_data = '0;
  end

  always_comb begin
    imm32 = 32'd0;
    case (opcode)
      OpImm, OpLoad, OpJalr: imm32 = {{20{instr[31]}}, instr[31:20]};
      OpStore:               imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OpBranch:              imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      OpJal:                 imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      OpLui, OpAuipc:        imm32 = {instr[31:12], 12'd0};
      default:               imm32 = 32'd0;
    endcase
    imm_d = DataWidth'($signed(imm32));
  end

  assign uses_rs1 = !((opcode == OpLui) || (opcode == OpAuipc) || (opcode == OpJal));
  assign uses_rs2 = (opcode == OpReg) || (opcode == OpStore) || (opcode == OpBranch);
  assign stall    = bus.if_valid && bus.ex_load && (bus.ex_rd != '0) &&
                    ((uses_rs1 && (bus.ex_rd == rs1)) || (uses_rs2 && (bus.ex_rd == rs2)));
  assign if_ready = rst && !bus.flush && !stall && (!id_valid_q || bus.id_ready);
  assign accept   = bus.if_valid && if_ready;

  // x0 is never written, so its entry stays at its reset value of zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < Depth; i++) rf_q[i] <= '0;
    end else if (wb_live) begin
      rf_q[bus.wb_rd] <= bus.wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      id_valid_q    <= 1'b0;
      id_pc_q       <= '0;
      id_imm_q      <= '0;
      id_rs1_data_q <= '0;
      id_rs2_data_q <= '0;
      id_rs1_q      <= '0;
      id_rs2_q      <= '0;
      id_rd_q       <= '0;
      id_opcode_q   <= '0;
      id_func3_q    <= '0;
      id_func7b_q   <= 1'b0;
    end else if (bus.flush) begin
      id_valid_q <= 1'b0;
    end else if (accept) begin
      id_valid_q    <= 1'b1;
      id_pc_q       <= bus.if_pc;
      id_imm_q      <= imm_d;
      id_rs1_data_q <= rs1_data;
      id_rs2_data_q <= rs2_data;
      id_rs1_q      <= rs1;
      id_rs2_q      <= rs2;
      id_rd_q       <= rd;
      id_opcode_q   <= opcode;
      id_func3_q    <= instr[14:12];
      id_func7b_q   <= instr[30];
    end else if (bus.id_ready) begin
      id_valid_q <= 1'b0;
    end else if (WbBypass && id_valid_q && wb_live) begin
      // A stalled bundle must not carry operands that went stale while it waited.
      if (bus.wb_rd == id_rs1_q) id_rs1_data_q <= bus.wb_data;
      if (bus.wb_rd == id_rs2_q) id_rs2_data_q <= bus.wb_data;
    end
  end

  assign bus.if_ready    = if_ready;
  assign bus.stall       = stall;
  assign bus.id_valid    = id_valid_q;
  assign bus.id_pc       = id_pc_q;
  assign bus.id_imm      = id_imm_q;
  assign bus.id_rs1_data = id_rs1_data_q;
  assign bus.id_rs2_data = id_rs2_data_q;
  assign bus.id_rs1      = id_rs1_q;
  assign bus.id_rs2      = id_rs2_q;
  assign bus.id_rd       = id_rd_q;
  assign bus.id_opcode   = id_opcode_q;
  assign bus.id_func3    = id_func3_q;
  assign bus.id_func7b   = id_func7b_q;
endmodule

// File: tb/tb_decode_pipe_stage.sv
// Directed bench for decode_pipe_stage: one bypassing instance and one non-bypassing
// instance share all stimulus; expected values are hand-computed from the ISA encodings.
module tb_decode_pipe_stage;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  decode_pipe_stage_if #(.DataWidth(32), .RegAddress(5)) bus ();
  decode_pipe_stage_if #(.DataWidth(32), .RegAddress(5)) bus_nb ();

  decode_pipe_stage #(.DataWidth(32), .RegAddress(5), .WbBypass(1'b1)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave));
  decode_pipe_stage #(.DataWidth(32), .RegAddress(5), .WbBypass(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .bus(bus_nb.slave));

  assign bus_nb.if_valid = bus.if_valid;
  assign bus_nb.if_instr = bus.if_instr;
  assign bus_nb.if_pc    = bus.if_pc;
  assign bus_nb.wb_en    = bus.wb_en;
  assign bus_nb.wb_rd    = bus.wb_rd;
  assign bus_nb.wb_data  = bus.wb_data;
  assign bus_nb.ex_load  = bus.ex_load;
  assign bus_nb.ex_rd    = bus.ex_rd;
  assign bus_nb.flush    = bus.flush;
  assign bus_nb.id_ready = bus.id_ready;

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] instr, input logic [31:0] pc);
    bus.if_valid = 1'b1;
    bus.if_instr = instr;
    bus.if_pc    = pc;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.id_ready = 1'b1;
    step();
    step();
    checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", bus.id_valid); end
    checks++; if (bus.id_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 0", bus.id_pc); end
    checks++; if (bus.id_imm !== 32'h0) begin errors++; $display("FAIL reset_imm got %h want 0", bus.id_imm); end
    checks++; if (bus.id_rs1_data !== 32'h0) begin errors++; $display("FAIL reset_rs1_data got %h want 0", bus.id_rs1_data); end
    checks++; if (bus.id_rd !== 5'd0) begin errors++; $display("FAIL reset_rd got %0d want 0", bus.id_rd); end
    checks++; if (bus.if_ready !== 1'b0) begin errors++; $display("FAIL reset_if_ready got %0b want 0", bus.if_ready); end
    rst = 1'b1;
    #1;
    checks++; if (bus.if_ready !== 1'b1) begin errors++; $display("FAIL post_reset_if_ready got %0b want 1", bus.if_ready); end
    $display("test_reset done");
  endtask

  task automatic test_addi();
    offer(32'h00500093, 32'h100);
    #1;
    checks++; if (bus.if_ready !== 1'b1) begin errors++; $display("FAIL addi_if_ready got %0b want 1", bus.if_ready); end
    step();
    bus.if_valid = 1'b0;
    checks++; if (bus.id_valid !== 1'b1) begin errors++; $display("FAIL addi_valid got %0b want 1", bus.id_valid); end
    checks++; if (bus.id_imm !== 32'd5) begin errors++; $display("FAIL addi_imm got %h want 5", bus.id_imm); end
    checks++; if (bus.id_rd !== 5'd1) begin errors++; $display("FAIL addi_rd got %0d want 1", bus.id_rd); end
    checks++; if (bus.id_rs1_data !== 32'h0) begin errors++; $display("FAIL addi_rs1_data got %h want 0", bus.id_rs1_data); end
    checks++; if (bus.id_pc !== 32'h100) begin errors++; $display("FAIL addi_pc got %h want 100", bus.id_pc); end
    checks++; if (bus.id_opcode !== 7'h13) begin errors++; $display("FAIL addi_opcode got %h want 13", bus.id_opcode); end
    $display("test_addi done");
  endtask

  task automatic test_bypass();
    bus.wb_en = 1'b1; bus.wb_rd = 5'd2; bus.wb_data = 32'hDEADBEEF;
    offer(32'h002101B3, 32'h104);
    step();
    bus.wb_en = 1'b0; bus.if_valid = 1'b0;
    checks++; if (bus.id_rs1_data !== 32'hDEADBEEF) begin errors++; $display("FAIL byp_rs1_data got %h want deadbeef", bus.id_rs1_data); end
    checks++; if (bus.id_rs2_data !== 32'hDEADBEEF) begin errors++; $display("FAIL byp_rs2_data got %h want deadbeef", bus.id_rs2_data); end
    checks++; if (bus_nb.id_rs1_data !== 32'h0) begin errors++; $display("FAIL nobyp_rs1_data got %h want 0", bus_nb.id_rs1_data); end
    checks++; if (bus_nb.id_rs2_data !== 32'h0) begin errors++; $display("FAIL nobyp_rs2_data got %h want 0", bus_nb.id_rs2_data); end
    checks++; if (bus.id_rd !== 5'd3) begin errors++; $display("FAIL add_rd got %0d want 3", bus.id_rd); end
    checks++; if (bus.id_rs2 !== 5'd2) begin errors++; $display("FAIL add_rs2 got %0d want 2", bus.id_rs2); end
    checks++; if (bus.id_func7b !== 1'b0) begin errors++; $display("FAIL add_func7b got %0b want 0", bus.id_func7b); end
    step();
    checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL byp_bubble got %0b want 0", bus.id_valid); end
    $display("test_bypass done");
  endtask

  task automatic test_load_use();
    bus.ex_load = 1'b1; bus.ex_rd = 5'd2;
    offer(32'h002101B3, 32'h108);
    #1;
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL lu_stall got %0b want 1", bus.stall); end
    checks++; if (bus.if_ready !== 1'b0) begin errors++; $display("FAIL lu_if_ready got %0b want 0", bus.if_ready); end
    step();
    checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble got %0b want 0", bus.id_valid); end
    bus.ex_rd = 5'd0;
    #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL lu_x0_stall got %0b want 0", bus.stall); end
    bus.ex_rd = 5'd2;
    bus.if_instr = 32'h000102B7;
    #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL lu_lui_stall got %0b want 0", bus.stall); end
    bus.if_instr = 32'h002101B3;
    bus.ex_load = 1'b0;
    #1;
    checks++; if (bus.if_ready !== 1'b1) begin errors++; $display("FAIL lu_release got %0b want 1", bus.if_ready); end
    step();
    bus.if_valid = 1'b0;
    checks++; if (bus.id_valid !== 1'b1) begin errors++; $display("FAIL lu_accept got %0b want 1", bus.id_valid); end
    checks++; if (bus.id_rs1_data !== 32'hDEADBEEF) begin errors++; $display("FAIL lu_rs1_data got %h want deadbeef", bus.id_rs1_data); end
    checks++; if (bus_nb.id_rs1_data !== 32'hDEADBEEF) begin errors++; $display("FAIL nobyp_rf_rs1 got %h want deadbeef", bus_nb.id_rs1_data); end
    $display("test_load_use done");
  endtask

  task automatic test_hold();
    bus.id_ready = 1'b0;
    bus.wb_en = 1'b1; bus.wb_rd = 5'd2; bus.wb_data = 32'd7;
    offer(32'h00500093, 32'h200);
    #1;
    checks++; if (bus.if_ready !== 1'b0) begin errors++; $display("FAIL hold_if_ready got %0b want 0", bus.if_ready); end
    step();
    bus.wb_en = 1'b0;
    checks++; if (bus.id_rs1_data !== 32'd7) begin errors++; $display("FAIL hold_rs1_refresh got %h want 7", bus.id_rs1_data); end
    checks++; if (bus.id_rs2_data !== 32'd7) begin errors++; $display("FAIL hold_rs2_refresh got %h want 7", bus.id_rs2_data); end
    checks++; if (bus_nb.id_rs1_data !== 32'hDEADBEEF) begin errors++; $display("FAIL nobyp_hold got %h want deadbeef", bus_nb.id_rs1_data); end
    step();
    step();
    checks++; if (bus.id_valid !== 1'b1) begin errors++; $display("FAIL hold_valid got %0b want 1", bus.id_valid); end
    checks++; if (bus.id_pc !== 32'h108) begin errors++; $display("FAIL hold_pc got %h want 108", bus.id_pc); end
    bus.if_valid = 1'b0;
    bus.id_ready = 1'b1;
    step();
    checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL hold_transfer got %0b want 0", bus.id_valid); end
    step();
    checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL hold_single got %0b want 0", bus.id_valid); end
    bus.wb_en = 1'b1; bus.wb_rd = 5'd0; bus.wb_data = 32'd9;
    offer(32'h00500093, 32'h20C);
    step();
    bus.wb_en = 1'b0;
    checks++; if (bus.id_rs1_data !== 32'h0) begin errors++; $display("FAIL x0_bypass got %h want 0", bus.id_rs1_data); end
    offer(32'h00500093, 32'h210);
    step();
    bus.if_valid = 1'b0;
    checks++; if (bus.id_rs1_data !== 32'h0) begin errors++; $display("FAIL x0_write got %h want 0", bus.id_rs1_data); end
    $display("test_hold done");
  endtask

  task automatic test_imm();
    logic [31:0] instrs [5] = '{32'h0020A423, 32'hFF9FF0EF, 32'h000102B7, 32'hFFF0000F, 32'hFFF00093};
    logic [31:0] imms   [5] = '{32'h00000008, 32'hFFFFFFF8, 32'h00010000, 32'h00000000, 32'hFFFFFFFF};
    for (int i = 0; i < 5; i++) begin
      offer(instrs[i], 32'h400 + 32'(i * 4));
      step();
      bus.if_valid = 1'b0;
      checks++; if (bus.id_imm !== imms[i]) begin errors++; $display("FAIL imm_%0d instr %h got %h want %h", i, instrs[i], bus.id_imm, imms[i]); end
      $display("imm vector %0d instr %h imm %h", i, instrs[i], bus.id_imm);
    end
  endtask

  task automatic test_branch_flush();
    offer(32'hFE000EE3, 32'h300);
    step();
    checks++; if (bus.id_imm !== 32'hFFFFFFFC) begin errors++; $display("FAIL beq_imm got %h want fffffffc", bus.id_imm); end
    checks++; if (bus.id_opcode !== 7'h63) begin errors++; $display("FAIL beq_opcode got %h want 63", bus.id_opcode); end
    bus.id_ready = 1'b0;
    bus.flush = 1'b1;
    offer(32'h00500093, 32'h304);
    #1;
    checks++; if (bus.if_ready !== 1'b0) begin errors++; $display("FAIL flush_if_ready got %0b want 0", bus.if_ready); end
    step();
    checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %0b want 0", bus.id_valid); end
    bus.flush = 1'b0;
    bus.id_ready = 1'b1;
    #1;
    checks++; if (bus.if_ready !== 1'b1) begin errors++; $display("FAIL post_flush_ready got %0b want 1", bus.if_ready); end
    step();
    bus.if_valid = 1'b0;
    checks++; if (bus.id_pc !== 32'h304) begin errors++; $display("FAIL post_flush_pc got %h want 304", bus.id_pc); end
    $display("test_branch_flush done");
  endtask

  initial begin
    bus.if_valid = 1'b0; bus.if_instr = '0; bus.if_pc = '0;
    bus.wb_en = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;
    bus.ex_load = 1'b0; bus.ex_rd = '0; bus.flush = 1'b0; bus.id_ready = 1'b1;
    test_reset();
    test_addi();
    test_bypass();
    test_load_use();
    test_hold();
    test_imm();
    test_branch_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
